// File: rtl/wt_arb_pkg.sv
// Shared types for the write-through refill arbiter.
// Owner and state encodings plus line geometry helpers.
package wt_arb_pkg;

  localparam int unsigned LINE_W = 128;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 64;

  typedef enum logic [1:0] {
    OWNER_IC = 2'd0,
    OWNER_DC = 2'd1,
    OWNER_WB = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RSP,
    S_DONE
  } state_e;

  function automatic int unsigned line_off_w(
    input int unsigned line_w
  );
    return $clog2(line_w / 8);
  endfunction

  function automatic owner_e owner_next(
    input owner_e o
  );
    owner_e r;
    unique case (o)
      OWNER_IC: r = OWNER_DC;
      OWNER_DC: r = OWNER_WB;
      default:  r = OWNER_IC;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wt_refill_arbiter_rr_arb3.sv
// Three-way round-robin arbiter with a write-buffer
// ordering override; grant is one-hot.
module rr_arb3
  import wt_arb_pkg::*;
(
  input  logic [2:0] req,
  input  owner_e     ptr,
  input  logic       force_wb,
  output logic [2:0] gnt,
  output owner_e     next_ptr
);

  logic [5:0] dbl;
  logic [2:0] pidx;
  logic [2:0] rot;
  owner_e     win;

  // rot[k] is the request k places after the pointer
  assign dbl  = {req, req};
  assign pidx = {1'b0, ptr};
  assign rot  = dbl[pidx +: 3];

  always_comb begin
    win = ptr;
    if (force_wb && req[2]) begin
      win = OWNER_WB;
    end else if (rot[0]) begin
      win = ptr;
    end else if (rot[1]) begin
      win = owner_next(ptr);
    end else begin
      win = owner_next(owner_next(ptr));
    end
    gnt      = (|req) ? (3'b001 << win) : 3'b000;
    next_ptr = (|req) ? owner_next(win) : ptr;
  end

endmodule

// File: rtl/wt_refill_arbiter.sv
// Shares one memory port between I$ refill, D$ refill
// and write-buffer drain; assembles refill lines.
module wt_refill_arbiter
  import wt_arb_pkg::*;
#(
  parameter int unsigned LineWidth = LINE_W,
  parameter int unsigned DataWidth = DATA_W,
  parameter int unsigned AddrWidth = ADDR_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   ic_req_valid_i,
  output logic                   ic_req_ready_o,
  input  logic [AddrWidth-1:0]   ic_req_addr_i,
  input  logic                   dc_req_valid_i,
  output logic                   dc_req_ready_o,
  input  logic [AddrWidth-1:0]   dc_req_addr_i,
  input  logic                   wb_req_valid_i,
  output logic                   wb_req_ready_o,
  input  logic [AddrWidth-1:0]   wb_req_addr_i,
  input  logic [DataWidth-1:0]   wb_req_wdata_i,
  input  logic [DataWidth/8-1:0] wb_req_be_i,
  output logic                   ic_rsp_valid_o,
  output logic                   dc_rsp_valid_o,
  output logic [LineWidth-1:0]   rsp_line_o,
  output logic                   wb_rsp_valid_o,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic [AddrWidth-1:0]   mem_req_addr_o,
  output logic                   mem_req_we_o,
  output logic [1:0]             mem_req_len_o,
  output logic [DataWidth-1:0]   mem_req_wdata_o,
  output logic [DataWidth/8-1:0] mem_req_be_o,
  input  logic                   mem_rsp_valid_i,
  input  logic [DataWidth-1:0]   mem_rsp_data_i,
  input  logic                   mem_rsp_last_i
);

  localparam int unsigned NumBeats = LineWidth / DataWidth;
  localparam int unsigned OffW = line_off_w(LineWidth);
  localparam int unsigned BeW = DataWidth / 8;
  localparam int unsigned BeatW =
    (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam int unsigned CntW = BeatW + 1;

  state_e                state;
  owner_e                owner;
  owner_e                rr_ptr;
  owner_e                next_ptr;
  owner_e                win;
  logic [2:0]            req;
  logic [2:0]            gnt;
  logic                  force_wb;
  logic                  accept;
  logic [CntW-1:0]       cnt;
  logic [BeatW-1:0]      beat;
  logic [AddrWidth-1:0]  sel_addr;
  logic [DataWidth-1:0]  sel_wdata;
  logic [BeW-1:0]        sel_be;

  assign req = {wb_req_valid_i, dc_req_valid_i,
                ic_req_valid_i};

  // a store to the line being refilled must land first
  assign force_wb = dc_req_valid_i & wb_req_valid_i &
    (dc_req_addr_i[AddrWidth-1:OffW] ==
     wb_req_addr_i[AddrWidth-1:OffW]);

  rr_arb3 u_arb (
    .req      (req),
    .ptr      (rr_ptr),
    .force_wb (force_wb),
    .gnt      (gnt),
    .next_ptr (next_ptr)
  );

  assign accept = rst_ni & (state == S_IDLE) & (|req);
  assign ic_req_ready_o = accept & gnt[0];
  assign dc_req_ready_o = accept & gnt[1];
  assign wb_req_ready_o = accept & gnt[2];

  always_comb begin
    win       = OWNER_WB;
    sel_addr  = wb_req_addr_i;
    sel_wdata = wb_req_wdata_i;
    sel_be    = wb_req_be_i;
    unique case (1'b1)
      gnt[0]: begin
        win       = OWNER_IC;
        sel_addr  = {ic_req_addr_i[AddrWidth-1:OffW],
                     {OffW{1'b0}}};
        sel_wdata = '0;
        sel_be    = '0;
      end
      gnt[1]: begin
        win       = OWNER_DC;
        sel_addr  = {dc_req_addr_i[AddrWidth-1:OffW],
                     {OffW{1'b0}}};
        sel_wdata = '0;
        sel_be    = '0;
      end
      default: ;
    endcase
  end

  assign beat = cnt[BeatW-1:0];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state           <= S_IDLE;
      owner           <= OWNER_IC;
      rr_ptr          <= OWNER_IC;
      cnt             <= '0;
      ic_rsp_valid_o  <= 1'b0;
      dc_rsp_valid_o  <= 1'b0;
      wb_rsp_valid_o  <= 1'b0;
      rsp_line_o      <= '0;
      mem_req_valid_o <= 1'b0;
      mem_req_addr_o  <= '0;
      mem_req_we_o    <= 1'b0;
      mem_req_len_o   <= '0;
      mem_req_wdata_o <= '0;
      mem_req_be_o    <= '0;
    end else begin
      ic_rsp_valid_o <= 1'b0;
      dc_rsp_valid_o <= 1'b0;
      wb_rsp_valid_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (|req) begin
            owner           <= win;
            rr_ptr          <= next_ptr;
            mem_req_valid_o <= 1'b1;
            mem_req_addr_o  <= sel_addr;
            mem_req_we_o    <= (win == OWNER_WB);
            mem_req_len_o   <= (win == OWNER_WB) ?
                               2'd0 : 2'(NumBeats - 1);
            mem_req_wdata_o <= sel_wdata;
            mem_req_be_o    <= sel_be;
            state           <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            cnt             <= '0;
            state           <= S_RSP;
          end
        end
        S_RSP: begin
          if (mem_rsp_valid_i) begin
            if (!mem_req_we_o &&
                cnt < CntW'(NumBeats)) begin
              rsp_line_o[beat*DataWidth +: DataWidth]
                <= mem_rsp_data_i;
            end
            cnt <= cnt + 1'b1;
            if (mem_rsp_last_i) begin
              ic_rsp_valid_o <= (owner == OWNER_IC);
              dc_rsp_valid_o <= (owner == OWNER_DC);
              wb_rsp_valid_o <= (owner == OWNER_WB);
              state          <= S_DONE;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  a_early_last: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (state == S_RSP && mem_rsp_valid_i &&
     mem_rsp_last_i && !mem_req_we_o)
    |-> (cnt == CntW'(NumBeats - 1)));

  a_overrun: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (state == S_RSP && mem_rsp_valid_i)
    |-> (cnt < CntW'(NumBeats)));

  a_stray_rsp: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    mem_rsp_valid_i |-> (state == S_RSP));

endmodule

// File: tb/tb_wt_refill_arbiter.sv
// Scoreboard bench for wt_refill_arbiter: requester and
// memory models, directed cases then random traffic.
module tb_wt_refill_arbiter;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
  } req_t;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [1:0]  len;
    logic [63:0] wdata;
    logic [7:0]  be;
  } mexp_t;

  typedef struct {
    int           owner;
    logic [127:0] line;
  } rexp_t;

  typedef struct {
    logic [63:0] addr;
    int          nb;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   rv;
  logic [63:0]  ra [3];
  logic [63:0]  wb_wdata;
  logic [7:0]   wb_be;
  logic         ic_rdy, dc_rdy, wb_rdy;
  logic         ic_pulse, dc_pulse, wb_pulse;
  logic [127:0] line;
  logic         mreq_v, mreq_rdy, mreq_we;
  logic [63:0]  mreq_addr, mreq_wdata;
  logic [1:0]   mreq_len;
  logic [7:0]   mreq_be;
  logic         mrsp_v, mrsp_last;
  logic [63:0]  mrsp_data;

  req_t  rq [3][$];
  mexp_t exp_mem [$];
  rexp_t exp_rsp [$];
  beat_t resp_q [$];
  int    grant_log [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit busy;
  int ptr;
  int acc_cyc;
  bit best_case = 0;
  bit eager = 1;
  bit zero_gap = 1;
  bit rand_ready = 0;
  int stall_target = 0;
  logic [127:0] last_line;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wt_refill_arbiter dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .ic_req_valid_i  (rv[0]),
    .ic_req_ready_o  (ic_rdy),
    .ic_req_addr_i   (ra[0]),
    .dc_req_valid_i  (rv[1]),
    .dc_req_ready_o  (dc_rdy),
    .dc_req_addr_i   (ra[1]),
    .wb_req_valid_i  (rv[2]),
    .wb_req_ready_o  (wb_rdy),
    .wb_req_addr_i   (ra[2]),
    .wb_req_wdata_i  (wb_wdata),
    .wb_req_be_i     (wb_be),
    .ic_rsp_valid_o  (ic_pulse),
    .dc_rsp_valid_o  (dc_pulse),
    .rsp_line_o      (line),
    .wb_rsp_valid_o  (wb_pulse),
    .mem_req_valid_o (mreq_v),
    .mem_req_ready_i (mreq_rdy),
    .mem_req_addr_o  (mreq_addr),
    .mem_req_we_o    (mreq_we),
    .mem_req_len_o   (mreq_len),
    .mem_req_wdata_o (mreq_wdata),
    .mem_req_be_o    (mreq_be),
    .mem_rsp_valid_i (mrsp_v),
    .mem_rsp_data_i  (mrsp_data),
    .mem_rsp_last_i  (mrsp_last)
  );

  // memory contents as a pure function of address/beat
  function automatic logic [63:0] bd(
    input logic [63:0] a, input int b);
    if (a == 64'h8000_0010)
      return (b == 0) ? 64'h1111_1111_1111_1111
                      : 64'h2222_2222_2222_2222;
    return {a[31:0], 32'(b)} ^ 64'hA5A5_0000_5A5A_0000;
  endfunction

  function automatic logic [63:0] align(
    input logic [63:0] a);
    return {a[63:4], 4'h0};
  endfunction

  // who should win: same-line store first, else rotate
  function automatic int pick(
    input logic [2:0] v, input logic [63:0] dca,
    input logic [63:0] wba, input int p);
    if (v[1] && v[2] && dca[63:4] == wba[63:4])
      return 2;
    for (int k = 0; k < 3; k++)
      if (v[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction

  function automatic int oh_idx(input logic [2:0] x);
    return x[0] ? 0 : (x[1] ? 1 : 2);
  endfunction

  // requester drivers
  initial begin
    bit done [3];
    rv = '0;
    wb_wdata = '0;
    wb_be = '0;
    for (int i = 0; i < 3; i++) ra[i] = '0;
    forever begin
      @(negedge clk);
      done[0] = rst_n && rv[0] && ic_rdy;
      done[1] = rst_n && rv[1] && dc_rdy;
      done[2] = rst_n && rv[2] && wb_rdy;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          rv[i] = 1'b0;
        end else begin
          if (done[i]) begin
            rv[i] = 1'b0;
            rq[i].delete(0);
          end
          if (!rv[i] && rq[i].size() > 0 &&
              (eager || $urandom_range(0, 3) == 0)) begin
            rv[i] = 1'b1;
            ra[i] = rq[i][0].addr;
            if (i == 2) begin
              wb_wdata = rq[i][0].wdata;
              wb_be    = rq[i][0].be;
            end
          end
        end
      end
    end
  end

  // memory port: request ready
  initial begin
    int stall_done;
    stall_done = 0;
    mreq_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_done < stall_target && mreq_v) begin
        mreq_rdy = 1'b0;
        stall_done++;
      end else begin
        mreq_rdy = rand_ready ?
          ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  // memory port: response beats
  initial begin
    int beat_idx;
    beat_idx = 0;
    mrsp_v = 1'b0;
    mrsp_last = 1'b0;
    mrsp_data = '0;
    forever begin
      @(posedge clk);
      #1;
      mrsp_v = 1'b0;
      mrsp_last = 1'b0;
      if (!rst_n) begin
        resp_q.delete();
        beat_idx = 0;
      end else if (resp_q.size() > 0 &&
                   (zero_gap || $urandom_range(0, 2) != 0)) begin
        mrsp_v = 1'b1;
        mrsp_data = bd(resp_q[0].addr, beat_idx);
        beat_idx++;
        if (beat_idx == resp_q[0].nb) begin
          mrsp_last = 1'b1;
          beat_idx = 0;
          resp_q.delete(0);
        end
      end
    end
  end

  // monitor and scoreboard
  initial begin
    logic [2:0] rdy, p;
    int w, got;
    bit stalled;
    mexp_t sv, e;
    rexp_t r;
    logic [63:0] a;
    stalled = 0;
    busy = 0;
    ptr = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_mem.delete();
        exp_rsp.delete();
        busy = 0;
        ptr = 0;
        stalled = 0;
        continue;
      end
      rdy = {wb_rdy, dc_rdy, ic_rdy};
      if (rdy != 3'b000) begin
        checks++;
        if (!$onehot(rdy) || (rdy & ~rv) != 0 || busy) begin
          errors++;
          $display("FAIL ready_grant: ready=%b valid=%b busy=%0d",
                   rdy, rv, busy);
        end else begin
          got = oh_idx(rdy);
          w = pick(rv, ra[1], ra[2], ptr);
          checks++;
          if (got != w) begin
            errors++;
            $display("FAIL arb_order: granted=%0d expected=%0d",
                     got, w);
          end
          grant_log.push_back(got);
          ptr = (got + 1) % 3;
          busy = 1;
          acc_cyc = cyc;
          e.we    = (got == 2);
          e.addr  = e.we ? ra[2] : align(ra[got]);
          e.len   = e.we ? 2'd0 : 2'd1;
          e.wdata = wb_wdata;
          e.be    = wb_be;
          exp_mem.push_back(e);
          r.owner = got;
          r.line  = {bd(e.addr, 1), bd(e.addr, 0)};
          exp_rsp.push_back(r);
        end
      end else if (rv != 3'b000 && !busy) begin
        checks++;
        errors++;
        $display("FAIL missed_grant: ready=%b valid=%b", rdy, rv);
      end
      if (stalled) begin
        checks++;
        if (!mreq_v || mreq_addr != sv.addr ||
            mreq_we != sv.we || mreq_len != sv.len ||
            mreq_wdata != sv.wdata || mreq_be != sv.be) begin
          errors++;
          $display("FAIL req_stable: addr=%h was %h v=%b",
                   mreq_addr, sv.addr, mreq_v);
        end
      end
      stalled = 0;
      if (mreq_v) begin
        if (mreq_rdy) begin
          checks++;
          if (exp_mem.size() == 0) begin
            errors++;
            $display("FAIL mem_req: unexpected addr=%h", mreq_addr);
          end else begin
            e = exp_mem.pop_front();
            if (mreq_addr != e.addr || mreq_we != e.we ||
                mreq_len != e.len || (e.we &&
                (mreq_wdata != e.wdata || mreq_be != e.be))) begin
              errors++;
              $display("FAIL mem_req: got a=%h we=%b len=%0d d=%h be=%h want a=%h we=%b len=%0d d=%h be=%h",
                       mreq_addr, mreq_we, mreq_len, mreq_wdata,
                       mreq_be, e.addr, e.we, e.len, e.wdata, e.be);
            end
            a = e.addr;
            resp_q.push_back('{addr: a, nb: e.we ? 1 : 2});
          end
        end else begin
          stalled = 1;
          sv = '{addr: mreq_addr, we: mreq_we, len: mreq_len,
                 wdata: mreq_wdata, be: mreq_be};
        end
      end
      p = {wb_pulse, dc_pulse, ic_pulse};
      if (p != 3'b000) begin
        checks++;
        if (!$onehot(p) || exp_rsp.size() == 0) begin
          errors++;
          $display("FAIL rsp_pulse: pulses=%b pending=%0d",
                   p, exp_rsp.size());
        end else begin
          r = exp_rsp.pop_front();
          got = oh_idx(p);
          if (got != r.owner || (got != 2 && line != r.line)) begin
            errors++;
            $display("FAIL rsp_data: owner=%0d line=%h want owner=%0d line=%h",
                     got, line, r.owner, r.line);
          end
          last_line = line;
          if (best_case) begin
            checks++;
            if (cyc - acc_cyc != 4) begin
              errors++;
              $display("FAIL latency: got=%0d want=4",
                       cyc - acc_cyc);
            end
          end
        end
        busy = 0;
      end
    end
  end

  task automatic push_req(input int i, input logic [63:0] a,
                          input logic [63:0] d,
                          input logic [7:0] be);
    rq[i].push_back('{addr: a, wdata: d, be: be});
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rq[0].size() == 0 && rq[1].size() == 0 &&
          rq[2].size() == 0 && rv == 3'b000 && !busy &&
          exp_mem.size() == 0 && exp_rsp.size() == 0 &&
          resp_q.size() == 0) break;
      t++;
      if (t >= budget) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout: busy=%0d pending=%0d want 0",
                 busy, exp_rsp.size());
        break;
      end
    end
  endtask

  task automatic check_quiet(input string nm);
    checks++;
    if ({ic_rdy, dc_rdy, wb_rdy, ic_pulse, dc_pulse, wb_pulse,
         mreq_v, mreq_we, mreq_len} != '0 || line != '0 ||
        mreq_addr != '0 || mreq_wdata != '0 ||
        mreq_be != '0) begin
      errors++;
      $display("FAIL %s: ctl=%b line=%h addr=%h want all 0", nm,
               {ic_rdy, dc_rdy, wb_rdy, ic_pulse, dc_pulse,
                wb_pulse, mreq_v, mreq_we, mreq_len},
               line, mreq_addr);
    end
  endtask

  task automatic check_int(input string nm, input int got,
                           input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic check_line(input string nm,
                            input logic [127:0] want);
    checks++;
    if (last_line != want) begin
      errors++;
      $display("FAIL %s: got=%h want=%h", nm, last_line, want);
    end
  endtask

  initial begin
    logic [127:0] ref_line;
    logic [63:0] a;
    int n0, t;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset_state");
    #1 rst_n = 1'b1;

    best_case = 1;
    push_req(0, 64'h8000_0014, '0, '0);
    wait_drain(100);
    best_case = 0;
    ref_line = {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    check_line("ic_single_line", ref_line);
    check_int("ic_single_owner", grant_log[grant_log.size()-1], 0);

    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    n0 = grant_log.size();
    push_req(0, 64'h8000_0020, '0, '0);
    push_req(1, 64'h8000_0200, '0, '0);
    push_req(2, 64'h8000_0308, 64'h0123_4567_89AB_CDEF, 8'hFF);
    @(negedge clk);
    #1 rst_n = 1'b1;
    wait_drain(200);
    check_int("rr_first", grant_log[n0], 0);
    check_int("rr_second", grant_log[n0+1], 1);
    check_int("rr_third", grant_log[n0+2], 2);

    n0 = grant_log.size();
    push_req(0, 64'h8000_0040, '0, '0);
    wait_drain(100);
    push_req(1, 64'h8000_0100, '0, '0);
    push_req(2, 64'h8000_0108, 64'hCAFE_F00D_0000_1111, 8'hF0);
    wait_drain(200);
    check_int("override_wb_first", grant_log[n0+1], 2);
    check_int("override_dc_next", grant_log[n0+2], 1);

    stall_target += 5;
    push_req(1, 64'h8000_0480, '0, '0);
    push_req(0, 64'h8000_0500, '0, '0);
    wait_drain(200);

    n0 = grant_log.size();
    push_req(2, 64'h8000_0608, 64'hDEAD_BEEF_0BAD_F00D, 8'h0F);
    wait_drain(100);
    check_int("wb_store_owner", grant_log[n0], 2);

    push_req(0, 64'h8000_0700, '0, '0);
    t = 0;
    do begin
      @(negedge clk);
      #2;
      t++;
    end while (!mrsp_v && t < 100);
    if (!mrsp_v) begin
      checks++;
      errors++;
      $display("FAIL beat_wait: no beat within %0d cycles", t);
    end
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2;
    check_quiet("reset_mid_rsp");
    @(negedge clk);
    #1 rst_n = 1'b1;
    n0 = grant_log.size();
    a = 64'h8000_0710;
    push_req(0, a, '0, '0);
    wait_drain(100);
    check_int("after_reset_owner", grant_log[n0], 0);
    check_line("after_reset_line", {bd(a, 1), bd(a, 0)});

    eager = 0;
    zero_gap = 0;
    rand_ready = 1;
    for (int k = 0; k < 200; k++) begin
      int i;
      i = $urandom_range(0, 2);
      a = 64'h8000_0000 + (64'($urandom_range(0, 3)) << 4);
      if (i == 2)
        a = a + (64'($urandom_range(0, 1)) << 3);
      else
        a = a + 64'($urandom_range(0, 15));
      if (rq[i].size() < 3)
        push_req(i, a, {$urandom, $urandom}, 8'($urandom));
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end
    wait_drain(5000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wt_refill_arbiter.md
# wt_refill_arbiter

Arbitration and sequencing controller that shares the single 64-bit memory port between three requesters of the write-through cache subsystem: I$ line refill, D$ line refill, and D$ write-buffer drain. It grants one transaction at a time, assembles 128-bit refill lines from 64-bit beats, and routes each response back to its owner. It sits between the cache controllers and the AXI adapter.

## Interface
- `LineWidth`, 128, cache line width in bits (I$ and D$)
- `DataWidth`, 64, memory beat width; `NumBeats = LineWidth/DataWidth` (2)
- `AddrWidth`, 64, physical address width
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset; synchronous, active-low
- `ic_req_valid_i` / `ic_req_ready_o`  in/out  1  I$ refill request handshake
- `ic_req_addr_i`  in  AddrWidth  I$ miss address; line-aligned internally
- `dc_req_valid_i` / `dc_req_ready_o`  in/out  1  D$ refill request handshake
- `dc_req_addr_i`  in  AddrWidth  D$ miss address
- `wb_req_valid_i` / `wb_req_ready_o`  in/out  1  write-buffer store handshake
- `wb_req_addr_i`  in  AddrWidth  store address, DataWidth-aligned
- `wb_req_wdata_i`  in  DataWidth  store data
- `wb_req_be_i`  in  DataWidth/8  byte enables
- `ic_rsp_valid_o`, `dc_rsp_valid_o`  out  1  one-cycle line-delivered pulse
- `rsp_line_o`  out  LineWidth  assembled line, valid with either rsp pulse
- `wb_rsp_valid_o`  out  1  one-cycle store-acknowledged pulse
- `mem_req_valid_o` / `mem_req_ready_i`  out/in  1  memory request handshake
- `mem_req_addr_o`  out  AddrWidth  request address
- `mem_req_we_o`  out  1  1 = write
- `mem_req_len_o`  out  2  beats minus one (NumBeats-1 for reads, 0 for writes)
- `mem_req_wdata_o`, `mem_req_be_o`  out  DataWidth, DataWidth/8  write payload
- `mem_rsp_valid_i`  in  1  response beat valid (always accepted)
- `mem_rsp_data_i`  in  DataWidth  read beat data
- `mem_rsp_last_i`  in  1  final beat of transaction

## Operation
- States: IDLE, REQ, RSP, DONE.
- IDLE: if any valid, pick winner, latch owner/addr/payload, assert that requester's ready for exactly this cycle (accept), go REQ. Ready is otherwise 0.
- Arbitration: round-robin over {IC, DC, WB}; pointer advances to owner+1 on grant.
- Ordering override: if `dc_req_valid_i` and `wb_req_valid_i` both set and their addresses match in bits [AddrWidth-1:log2(LineWidth/8)], WB wins regardless of pointer (pointer still advances past WB).
- Read addresses are forced line-aligned (low log2(LineWidth/8) bits zeroed) on `mem_req_addr_o`.
- REQ: hold `mem_req_valid_o`=1 with stable fields until `mem_req_ready_i`; then go RSP, beat counter = 0.
- RSP: each `mem_rsp_valid_i` writes `mem_rsp_data_i` into line slice [cnt*DataWidth +: DataWidth] (beat 0 = low word), cnt++. On valid with last: go DONE. Writes expect one beat with last, data ignored.
- DONE: one cycle; pulse the owner's rsp_valid; `rsp_line_o` holds the assembled line; return to IDLE.
- Protocol error (last before NumBeats beats on a read, or beat count exceeding NumBeats): simulation assertion; RTL still ends on last.

## Timing
- Reset (`rst_ni`=0 at a clock edge): state IDLE, RR pointer = IC, beat counter 0, all valid/ready/rsp outputs 0, `rsp_line_o` and mem fields 0. Reset mid-transaction abandons it; no response pulse follows.
- Accept-to-`mem_req_valid_o`: 1 cycle. Read best case: accept at cycle 0, mem request cycle 1, beats cycles 2–3, rsp pulse cycle 4.
- Back-to-back: next grant no earlier than the cycle after DONE; at most one transaction in flight.
- `mem_rsp_valid_i` outside RSP is ignored (assertion).
- `rsp_line_o` stable from DONE until next RSP beat.

## Structure
- Shared package `wt_arb_pkg`: `owner_e` {OWNER_IC, OWNER_DC, OWNER_WB}, `state_e`, line-offset localparams.
- One natural sub-module: `rr_arb3` (3-way round-robin with priority override input, outputs one-hot grant and next pointer).

## Test plan
- Single I$ miss at 0x8000_0014, beats 0x1111…/0x2222… -> `mem_req_addr_o`=0x8000_0010, len=1, `ic_rsp_valid_o` with line {0x2222…,0x1111…}.
- All three valid from reset -> grants IC, DC, WB in order; each gets one rsp pulse.
- WB store 0x8000_0108 pending with DC miss 0x8000_0100, pointer at DC -> WB granted first, then DC.
- `mem_req_ready_i` held low 5 cycles -> request fields stable, no ready to requesters.
- Reset asserted during RSP after beat 0 -> all outputs 0 next cycle, no rsp pulse; new request served normally.
- WB store with be=0x0F -> one write beat, `wb_rsp_valid_o` single pulse, len=0.
